plb_cache_responder: RTL and testbench
======================================

// Module: plb_cache_responder
// PURPOSE
//  Protection Lookaside Buffer storage: fully-associative cache answering the MEM/SRAM slave side of the
//  PLB interface driven by the MPT walker's lookup stage. Reads return the cached RPA/permission word for a
//  lookup key, or all-zero on miss. Walker-side hit detection is |rdata, so zero data always means miss.
//  Writes fill or update entries. Sits beside the MPT walker; one instance per walker.
// PARAMETERS
//  NUM_ENTRIES  8   PLB entries, power of two, >= 2
//  DATA_WIDTH   64  entry payload width (rdata/wdata)
//  ADDR_WIDTH   64  lookup key width (plb_lookup_req packed into addr), compared in full
//  CNT_WIDTH    32  width of hit/miss statistic counters
// PORTS
//  clk_i                  in   1            clock
//  rst_i                  in   1            synchronous reset, active-high
//  plb_slave_mem_req      in   1            request
//  plb_slave_mem_gnt      out  1            grant (combinational)
//  plb_slave_mem_valid    out  1            response valid
//  plb_slave_mem_addr     in   ADDR_WIDTH   lookup key
//  plb_slave_mem_rdata    out  DATA_WIDTH   entry payload, 0 on miss
//  plb_slave_mem_wdata    in   DATA_WIDTH   fill payload
//  plb_slave_mem_we       in   1            1 = fill/update, 0 = lookup
//  plb_slave_mem_be       in   DATA_WIDTH/8 byte enables, writes only
//  plb_slave_mem_error    out  1            response error, qualified by valid
//  flush_i                in   1            invalidate all entries
//  hit_count_o            out  CNT_WIDTH    saturating read-hit counter
//  miss_count_o           out  CNT_WIDTH    saturating read-miss counter
// BEHAVIOUR
//  Reset (rst_i high at an edge): all entries invalid, repl_ptr=0, counters=0, valid=0, rdata=0, error=0.
//   The in-flight response is dropped. gnt=0 while rst_i is high.
//  Grant: gnt = req & ~flush_i & ~rst_i. Accepted when req&gnt at an edge. One request per cycle, no stalls.
//  Latency: valid asserts exactly 1 cycle after acceptance, for 1 cycle. rdata/error are registered and held
//   until the next response. No response backpressure. Back-to-back accepts give back-to-back valids.
//  Lookup (we=0):
//   - Hit = some valid entry with tag==addr. rdata=entry data; hit_count++.
//   - Miss: rdata=0; miss_count++.
//   - error=0. Multiple tag matches cannot occur: fills dedupe.
//  Fill (we=1):
//   - wdata&be-mask all zero -> error=1, no array change. Protects the zero-means-miss encoding.
//   - Tag hit -> update enabled bytes of that entry in place.
//   - Tag miss -> allocate the lowest-index invalid entry. If none is invalid, allocate entry[repl_ptr]
//     (FIFO victim) and increment repl_ptr modulo NUM_ENTRIES.
//   - Allocated entry: tag=addr, data=wdata with disabled bytes zeroed, valid=1.
//   - Response: valid=1, rdata=0, error as above.
//  Ordering: array updates at the accept edge. A lookup accepted the next cycle sees the new data.
//   Same-cycle collisions cannot occur (single port).
//  Flush: flush_i high at an edge clears all valid bits; repl_ptr=0. Counters are kept.
//   A response already in flight still completes with its captured data.
//  Counters: saturate at all-ones, no wrap. Only lookups count. Counters clear only on reset.
// TESTING
//  1 Reset, lookup addr=0x1000 -> gnt same cycle; valid next cycle, rdata=0, miss_count=1.
//  2 Fill addr=0x1000 wdata=0xABCD be=0xFF, then lookup 0x1000 next cycle -> rdata=0xABCD, hit_count=1.
//  3 Fill 9 distinct keys (NUM_ENTRIES=8) -> key#1 evicted (lookup misses), keys #2..#9 hit; repl_ptr=1.
//  4 Fill wdata=0 be=0xFF -> valid with error=1; later lookup of that key misses.
//    Partial be=0x0F update on an existing entry changes only the low 4 bytes.
//  5 flush_i asserted with req high -> gnt=0 that cycle; all prior keys miss afterwards; counters unchanged.
//  6 Force miss_count to all-ones, then one more miss -> counter stays all-ones.
//    Assert rst_i with a response in flight -> valid=0 next cycle, all state reset.

Source files
------------

// File: rtl/plb_cache_responder_if.sv
// rtl/plb_cache_responder_if.sv - PLB MEM/SRAM slave request/response bundle
// master: walker lookup stage (drives req/addr/wdata/we/be)
// slave : PLB storage (drives gnt/valid/rdata/error)
interface plb_cache_responder_if #(
    parameter int ADDR_WIDTH = 64,
    parameter int DATA_WIDTH = 64
);
    logic                      req;
    logic                      gnt;
    logic                      valid;
    logic [ADDR_WIDTH-1:0]     addr;
    logic [DATA_WIDTH-1:0]     rdata;
    logic [DATA_WIDTH-1:0]     wdata;
    logic                      we;
    logic [DATA_WIDTH/8-1:0]   be;
    logic                      error;

    modport master (
        output req, addr, wdata, we, be,
        input  gnt, valid, rdata, error
    );

    modport slave (
        input  req, addr, wdata, we, be,
        output gnt, valid, rdata, error
    );
endinterface

// File: rtl/plb_cache_responder.sv
// rtl/plb_cache_responder.sv - fully-associative PLB entry store behind the PLB MEM slave port
// clk_i, rst_i   : clock, synchronous active-high reset
// plb_slave_mem  : request/response bundle (slave side); rdata all-zero means miss
// flush_i        : invalidate every entry, keep statistics
// hit_count_o    : saturating lookup-hit counter
// miss_count_o   : saturating lookup-miss counter
module plb_cache_responder #(
    parameter int NUM_ENTRIES = 8,
    parameter int DATA_WIDTH  = 64,
    parameter int ADDR_WIDTH  = 64,
    parameter int CNT_WIDTH   = 32
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    plb_cache_responder_if.slave     plb_slave_mem,
    input  logic                     flush_i,
    output logic [CNT_WIDTH-1:0]     hit_count_o,
    output logic [CNT_WIDTH-1:0]     miss_count_o
);
    localparam int IDX_W = $clog2(NUM_ENTRIES);
    localparam int BE_W  = DATA_WIDTH / 8;

    logic [NUM_ENTRIES-1:0] valid_q, valid_d;
    logic [ADDR_WIDTH-1:0]  tag_q  [NUM_ENTRIES];
    logic [ADDR_WIDTH-1:0]  tag_d  [NUM_ENTRIES];
    logic [DATA_WIDTH-1:0]  data_q [NUM_ENTRIES];
    logic [DATA_WIDTH-1:0]  data_d [NUM_ENTRIES];
    logic [IDX_W-1:0]       repl_ptr_q, repl_ptr_d;
    logic                   resp_valid_q, resp_valid_d;
    logic [DATA_WIDTH-1:0]  rdata_q, rdata_d;
    logic                   error_q, error_d;
    logic [CNT_WIDTH-1:0]   hit_cnt_q, hit_cnt_d;
    logic [CNT_WIDTH-1:0]   miss_cnt_q, miss_cnt_d;

    logic                   accept;
    logic                   hit;
    logic [IDX_W-1:0]       hit_idx;
    logic                   free;
    logic [IDX_W-1:0]       free_idx;
    logic [IDX_W-1:0]       alloc_idx;
    logic [DATA_WIDTH-1:0]  be_mask;
    logic [DATA_WIDTH-1:0]  wmasked;

    assign plb_slave_mem.gnt   = plb_slave_mem.req & ~flush_i & ~rst_i;
    assign plb_slave_mem.valid = resp_valid_q;
    assign plb_slave_mem.rdata = rdata_q;
    assign plb_slave_mem.error = error_q;
    assign hit_count_o         = hit_cnt_q;
    assign miss_count_o        = miss_cnt_q;

    assign accept  = plb_slave_mem.req & plb_slave_mem.gnt;
    assign wmasked = plb_slave_mem.wdata & be_mask;

    always_comb begin
        be_mask = '0;
        for (int b = 0; b < BE_W; b++) begin
            be_mask[b*8 +: 8] = {8{plb_slave_mem.be[b]}};
        end
    end

    // Fills never create a duplicate tag, so at most one entry matches.
    always_comb begin
        hit     = 1'b0;
        hit_idx = '0;
        for (int i = 0; i < NUM_ENTRIES; i++) begin
            if (valid_q[i] && tag_q[i] == plb_slave_mem.addr) begin
                hit     = 1'b1;
                hit_idx = IDX_W'(i);
            end
        end
    end

    // Scan downwards so the lowest-index invalid entry wins.
    always_comb begin
        free     = 1'b0;
        free_idx = '0;
        for (int i = NUM_ENTRIES - 1; i >= 0; i--) begin
            if (!valid_q[i]) begin
                free     = 1'b1;
                free_idx = IDX_W'(i);
            end
        end
    end

    assign alloc_idx = free ? free_idx : repl_ptr_q;

    always_comb begin
        valid_d      = valid_q;
        tag_d        = tag_q;
        data_d       = data_q;
        repl_ptr_d   = repl_ptr_q;
        resp_valid_d = accept;
        rdata_d      = rdata_q;
        error_d      = error_q;
        hit_cnt_d    = hit_cnt_q;
        miss_cnt_d   = miss_cnt_q;

        if (flush_i) begin
            valid_d    = '0;
            repl_ptr_d = '0;
        end else if (accept) begin
            if (plb_slave_mem.we) begin
                rdata_d = '0;
                // An all-zero entry would read back as a miss, so such fills are refused.
                error_d = (wmasked == '0);
                if (wmasked != '0) begin
                    if (hit) begin
                        data_d[hit_idx] = (data_q[hit_idx] & ~be_mask) | wmasked;
                    end else begin
                        valid_d[alloc_idx] = 1'b1;
                        tag_d[alloc_idx]   = plb_slave_mem.addr;
                        data_d[alloc_idx]  = wmasked;
                        if (!free) begin
                            repl_ptr_d = repl_ptr_q + IDX_W'(1);
                        end
                    end
                end
            end else begin
                error_d = 1'b0;
                if (hit) begin
                    rdata_d = data_q[hit_idx];
                    if (hit_cnt_q != '1) hit_cnt_d = hit_cnt_q + CNT_WIDTH'(1);
                end else begin
                    rdata_d = '0;
                    if (miss_cnt_q != '1) miss_cnt_d = miss_cnt_q + CNT_WIDTH'(1);
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            valid_q      <= '0;
            repl_ptr_q   <= '0;
            resp_valid_q <= 1'b0;
            rdata_q      <= '0;
            error_q      <= 1'b0;
            hit_cnt_q    <= '0;
            miss_cnt_q   <= '0;
        end else begin
            valid_q      <= valid_d;
            repl_ptr_q   <= repl_ptr_d;
            resp_valid_q <= resp_valid_d;
            rdata_q      <= rdata_d;
            error_q      <= error_d;
            hit_cnt_q    <= hit_cnt_d;
            miss_cnt_q   <= miss_cnt_d;
        end
    end

    // Tags and payloads are qualified by valid_q and need no reset.
    always_ff @(posedge clk_i) begin
        tag_q  <= tag_d;
        data_q <= data_d;
    end
endmodule

// File: tb/tb_plb_cache_responder.sv
// tb/tb_plb_cache_responder.sv - directed self-checking bench for plb_cache_responder
module tb_plb_cache_responder;
    localparam int CW  = 4;
    localparam int SAT = 15;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic flush = 1'b0;
    logic [CW-1:0] hit_cnt, miss_cnt;
    int checks = 0;
    int failures = 0;
    int hit_e = 0;
    int miss_e = 0;

    plb_cache_responder_if #(.ADDR_WIDTH(64), .DATA_WIDTH(64)) bus ();

    plb_cache_responder #(
        .NUM_ENTRIES(8), .DATA_WIDTH(64), .ADDR_WIDTH(64), .CNT_WIDTH(CW)
    ) dut (
        .clk_i(clk), .rst_i(rst), .plb_slave_mem(bus.slave), .flush_i(flush),
        .hit_count_o(hit_cnt), .miss_count_o(miss_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic int sat_inc(input int v);
        return (v >= SAT) ? SAT : v + 1;
    endfunction

    task automatic check_counters(input string tag);
        chk({tag, ".hit_count"}, 64'(hit_cnt), 64'(hit_e));
        chk({tag, ".miss_count"}, 64'(miss_cnt), 64'(miss_e));
    endtask

    // One accepted transaction: drive at negedge, accept at posedge, check response #1 later.
    task automatic xact(input string tag, input logic we, input logic [63:0] addr,
                        input logic [63:0] wdata, input logic [7:0] be,
                        input logic [63:0] exp_rdata, input logic exp_err);
        @(negedge clk);
        bus.req = 1'b1; bus.we = we; bus.addr = addr; bus.wdata = wdata; bus.be = be;
        #1 chk({tag, ".gnt"}, 64'(bus.gnt), 64'd1);
        @(posedge clk);
        #1;
        bus.req = 1'b0;
        if (!we) begin
            if (exp_rdata != 64'd0) hit_e = sat_inc(hit_e);
            else                    miss_e = sat_inc(miss_e);
        end
        chk({tag, ".valid"}, 64'(bus.valid), 64'd1);
        chk({tag, ".rdata"}, bus.rdata, exp_rdata);
        chk({tag, ".error"}, 64'(bus.error), 64'(exp_err));
        check_counters(tag);
    endtask

    task automatic fill(input string tag, input logic [63:0] addr, input logic [63:0] wdata,
                        input logic [7:0] be, input logic exp_err);
        xact(tag, 1'b1, addr, wdata, be, 64'd0, exp_err);
    endtask

    task automatic lookup(input string tag, input logic [63:0] addr, input logic [63:0] exp);
        xact(tag, 1'b0, addr, 64'd0, 8'd0, exp, 1'b0);
    endtask

    initial begin
        bus.req = 1'b0; bus.we = 1'b0; bus.addr = '0; bus.wdata = '0; bus.be = '0;

        // 1: reset, gnt held low while rst_i is high, then a miss
        @(negedge clk);
        bus.req = 1'b1; bus.addr = 64'h1000;
        #1 chk("rst.gnt", 64'(bus.gnt), 64'd0);
        @(posedge clk); #1;
        chk("rst.valid", 64'(bus.valid), 64'd0);
        chk("rst.rdata", bus.rdata, 64'd0);
        chk("rst.error", 64'(bus.error), 64'd0);
        check_counters("rst");
        @(negedge clk);
        bus.req = 1'b0; rst = 1'b0;
        lookup("t1.miss", 64'h1000, 64'd0);
        @(posedge clk); #1;
        chk("t1.idle_valid", 64'(bus.valid), 64'd0);
        chk("t1.rdata_held", bus.rdata, 64'd0);

        // 2: fill then back-to-back lookup sees the new data
        fill("t2.fill", 64'h1000, 64'hABCD, 8'hFF, 1'b0);
        lookup("t2.hit", 64'h1000, 64'hABCD);

        // 3: nine distinct keys, FIFO victim once the array is full
        for (int k = 2; k <= 9; k++) fill("t3.fill", 64'(k) << 12, 64'h100 + 64'(k), 8'hFF, 1'b0);
        lookup("t3.evicted", 64'h1000, 64'd0);
        for (int k = 2; k <= 9; k++) lookup("t3.hit", 64'(k) << 12, 64'h100 + 64'(k));
        fill("t3.fill_a", 64'hA000, 64'h10A, 8'hFF, 1'b0);
        lookup("t3.ptr1_evicted", 64'h2000, 64'd0);
        lookup("t3.ptr1_kept", 64'h3000, 64'h103);
        lookup("t3.new_a", 64'hA000, 64'h10A);

        // 4: zero-payload fills are refused, partial updates touch only enabled bytes
        fill("t4.zero_fill", 64'hB000, 64'd0, 8'hFF, 1'b1);
        lookup("t4.zero_miss", 64'hB000, 64'd0);
        fill("t4.masked_zero", 64'hB000, 64'hFF00, 8'h01, 1'b1);
        lookup("t4.masked_miss", 64'hB000, 64'd0);
        fill("t4.full_upd", 64'h3000, 64'hAAAA_BBBB_CCCC_DDDD, 8'hFF, 1'b0);
        lookup("t4.full_read", 64'h3000, 64'hAAAA_BBBB_CCCC_DDDD);
        fill("t4.part_upd", 64'h3000, 64'h1122_3344_5566_7788, 8'h0F, 1'b0);
        lookup("t4.part_read", 64'h3000, 64'hAAAA_BBBB_5566_7788);
        lookup("t4.no_realloc", 64'h4000, 64'h104);
        lookup("t4.no_realloc9", 64'h9000, 64'h109);

        // 5: flush blocks the grant, drops every entry, keeps counters
        @(negedge clk);
        bus.req = 1'b1; bus.we = 1'b0; bus.addr = 64'h4000; flush = 1'b1;
        #1 chk("t5.flush_gnt", 64'(bus.gnt), 64'd0);
        @(posedge clk); #1;
        chk("t5.flush_valid", 64'(bus.valid), 64'd0);
        check_counters("t5.flush");
        bus.req = 1'b0; flush = 1'b0;
        lookup("t5.miss4", 64'h4000, 64'd0);
        lookup("t5.miss3", 64'h3000, 64'd0);
        lookup("t5.missa", 64'hA000, 64'd0);

        // 6: miss counter saturation
        while (miss_e < SAT) lookup("t6.fill_miss", 64'hDEAD, 64'd0);
        lookup("t6.saturated", 64'hBEEF, 64'd0);
        chk("t6.miss_all_ones", 64'(miss_cnt), 64'd15);

        // 6: reset with a response in flight
        fill("t6.fill7", 64'h7000, 64'h7777, 8'hFF, 1'b0);
        @(negedge clk);
        bus.req = 1'b1; bus.we = 1'b0; bus.addr = 64'h7000;
        @(posedge clk); #1;
        bus.req = 1'b0; rst = 1'b1;
        chk("t6.inflight_valid", 64'(bus.valid), 64'd1);
        chk("t6.inflight_rdata", bus.rdata, 64'h7777);
        @(posedge clk); #1;
        hit_e = 0; miss_e = 0;
        chk("t6.rst_valid", 64'(bus.valid), 64'd0);
        chk("t6.rst_rdata", bus.rdata, 64'd0);
        check_counters("t6.rst");
        @(negedge clk);
        rst = 1'b0;
        lookup("t6.post_rst_miss", 64'h7000, 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
